// File: rtl/xvec2_vscale_vld_seq.sv
// Vector-load sequencer: strided scalar reads per masked lane, one masked commit to the vecfile write port.
// Latency: with full mask, ready memory and 1-cycle responses, the write lands 6 cycles after acceptance and done follows 1 cycle later.
// Backpressure: req_ready only in IDLE; mem_req_ready stalls issue; ALU writeback stalls the commit indefinitely.
module xvec2_vscale_vld_seq #(
    parameter int XPR_LEN        = 32,
    parameter int VEC_SIZE       = 4,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int VEC_XPR_LEN    = XPR_LEN * VEC_SIZE
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [REG_ADDR_WIDTH-1:0] req_rd,
    input  logic [XPR_LEN-1:0]        req_base,
    input  logic [XPR_LEN-1:0]        req_stride,
    input  logic [VEC_SIZE-1:0]       req_mask,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [XPR_LEN-1:0]        mem_req_addr,
    input  logic                      mem_resp_valid,
    input  logic [XPR_LEN-1:0]        mem_resp_data,
    input  logic                      alu_wen,
    input  logic [REG_ADDR_WIDTH-1:0] alu_wa,
    input  logic [VEC_SIZE-1:0]       alu_wmask,
    input  logic [VEC_XPR_LEN-1:0]    alu_wd,
    output logic                      vf_wen,
    output logic [REG_ADDR_WIDTH-1:0] vf_wa,
    output logic [VEC_SIZE-1:0]       vf_wmask,
    output logic [VEC_XPR_LEN-1:0]    vf_wd,
    output logic                      busy,
    output logic                      done
);
    localparam int IDX_W = $clog2(VEC_SIZE);
    localparam int CNT_W = $clog2(VEC_SIZE + 1);

    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    state_t                             state, state_nxt;
    logic [REG_ADDR_WIDTH-IDX_W-1:0]    rd_hi_q;
    logic [XPR_LEN-1:0]                 base_q, stride_q;
    logic [VEC_SIZE-1:0]                mask_q;
    logic [VEC_SIZE-1:0]                issue_left_q, resp_left_q;
    logic [CNT_W-1:0]                   outst_q;
    logic [VEC_XPR_LEN-1:0]             buf_q;
    logic                               done_q;

    logic [IDX_W-1:0]                   issue_idx, resp_idx;
    logic [VEC_SIZE-1:0]                issue_bit, resp_bit;
    logic                               issue_fire, resp_fire, resp_last;
    logic                               done_set;
    logic [VEC_XPR_LEN-1:0]             load_wd;
    logic                               unused_rd_lo;

    // Destination is a whole vector group, so the low lane-select bits of rd carry no meaning.
    assign unused_rd_lo = ^req_rd[IDX_W-1:0];

    function automatic logic [IDX_W-1:0] lowest(input logic [VEC_SIZE-1:0] m);
        lowest = '0;
        for (int i = VEC_SIZE - 1; i >= 0; i--) begin
            if (m[i]) lowest = IDX_W'(i);
        end
    endfunction

    assign issue_idx  = lowest(issue_left_q);
    assign resp_idx   = lowest(resp_left_q);
    assign issue_bit  = {{(VEC_SIZE-1){1'b0}}, 1'b1} << issue_idx;
    assign resp_bit   = {{(VEC_SIZE-1){1'b0}}, 1'b1} << resp_idx;
    assign issue_fire = mem_req_valid && mem_req_ready;
    // Responses with nothing outstanding are protocol errors and are dropped here.
    assign resp_fire  = (state == RUN) && mem_resp_valid && (outst_q != '0);
    assign resp_last  = resp_fire && ((resp_left_q & ~resp_bit) == '0);

    // Address uses the true lane number so skipped lanes still advance the stride.
    assign mem_req_addr = base_q + stride_q * XPR_LEN'(issue_idx);

    always_comb begin
        load_wd = '0;
        for (int i = 0; i < VEC_SIZE; i++) begin
            if (mask_q[i]) load_wd[i*XPR_LEN +: XPR_LEN] = buf_q[i*XPR_LEN +: XPR_LEN];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid && (req_mask != '0)) state_nxt = RUN;
            RUN:     if (resp_last) state_nxt = WB;
            WB:      if (!alu_wen) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (state == IDLE);
        busy          = (state != IDLE);
        mem_req_valid = (state == RUN) && (issue_left_q != '0);
        done_set      = ((state == IDLE) && req_valid && (req_mask == '0)) ||
                        ((state == WB) && !alu_wen);
        vf_wen        = alu_wen;
        vf_wa         = alu_wa;
        vf_wmask      = alu_wmask;
        vf_wd         = alu_wd;
        if ((state == WB) && !alu_wen) begin
            vf_wen   = 1'b1;
            vf_wa    = {rd_hi_q, {IDX_W{1'b0}}};
            vf_wmask = mask_q;
            vf_wd    = load_wd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_hi_q      <= '0;
            base_q       <= '0;
            stride_q     <= '0;
            mask_q       <= '0;
            issue_left_q <= '0;
            resp_left_q  <= '0;
            outst_q      <= '0;
            buf_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q  <= done_set;
            outst_q <= outst_q + CNT_W'(issue_fire) - CNT_W'(resp_fire);
            if ((state == IDLE) && req_valid) begin
                rd_hi_q      <= req_rd[REG_ADDR_WIDTH-1:IDX_W];
                base_q       <= req_base;
                stride_q     <= req_stride;
                mask_q       <= req_mask;
                issue_left_q <= req_mask;
                resp_left_q  <= req_mask;
            end
            if (issue_fire) issue_left_q <= issue_left_q & ~issue_bit;
            if (resp_fire) begin
                buf_q[resp_idx*XPR_LEN +: XPR_LEN] <= mem_resp_data;
                resp_left_q <= resp_left_q & ~resp_bit;
            end
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_xvec2_vscale_vld_seq.sv
// Bench for the vector-load sequencer: in-order memory model with random ready/latency, ALU override and reset abort.
module tb_xvec2_vscale_vld_seq;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic [4:0]   req_rd;
    logic [31:0]  req_base, req_stride;
    logic [3:0]   req_mask;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b1;
    logic [31:0]  mem_req_addr;
    logic         mem_resp_valid = 1'b0;
    logic [31:0]  mem_resp_data = '0;
    logic         alu_wen;
    logic [4:0]   alu_wa;
    logic [3:0]   alu_wmask;
    logic [127:0] alu_wd;
    logic         vf_wen;
    logic [4:0]   vf_wa;
    logic [3:0]   vf_wmask;
    logic [127:0] vf_wd;
    logic         busy, done;

    xvec2_vscale_vld_seq dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
        .req_base(req_base), .req_stride(req_stride), .req_mask(req_mask),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .alu_wen(alu_wen), .alu_wa(alu_wa), .alu_wmask(alu_wmask), .alu_wd(alu_wd),
        .vf_wen(vf_wen), .vf_wa(vf_wa), .vf_wmask(vf_wmask), .vf_wd(vf_wd),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit rdy_rand = 1'b0;
    int max_dly  = 1;

    typedef struct {
        int           c;
        logic [4:0]   wa;
        logic [3:0]   wm;
        logic [127:0] wd;
    } wr_t;

    wr_t         wr_log[$];
    int          done_log[$];
    logic [31:0] addr_log[$];
    int          acyc_log[$];
    logic [31:0] rq_data[$];
    int          rq_due[$];
    int          last_due = 0;
    int          d_tmp;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: accepts at negedge what the DUT will see accepted at the next posedge, answers in order after 1..max_dly cycles.
    always @(negedge clk) begin
        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = rq_data.pop_front();
            void'(rq_due.pop_front());
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
        end
        mem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mem_req_valid && mem_req_ready) begin
            addr_log.push_back(mem_req_addr);
            acyc_log.push_back(cyc);
            d_tmp = cyc + int'($urandom_range(1, max_dly));
            if (d_tmp <= last_due) d_tmp = last_due + 1;
            last_due = d_tmp;
            rq_data.push_back(mem_req_addr ^ 32'hA5A5A5A5);
            rq_due.push_back(d_tmp);
        end
        #1;
        if (vf_wen && !alu_wen) wr_log.push_back('{cyc, vf_wa, vf_wmask, vf_wd});
        if (done) done_log.push_back(cyc);
    end

    function automatic logic [127:0] model_wd(input logic [31:0] base, input logic [31:0] stride,
                                              input logic [3:0] mask);
        logic [127:0] w = '0;
        for (int i = 0; i < 4; i++)
            if (mask[i]) w[i*32 +: 32] = (base + 32'(i) * stride) ^ 32'hA5A5A5A5;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input logic [4:0] rd, input logic [31:0] base, input logic [31:0] stride,
                             input logic [3:0] mask, output int t0);
        tick();
        wr_log.delete(); done_log.delete(); addr_log.delete(); acyc_log.delete();
        req_rd = rd; req_base = base; req_stride = stride; req_mask = mask;
        req_valid = 1'b1;
        t0 = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_log.size() > 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; req_rd = '0; req_base = '0; req_stride = '0; req_mask = '0;
        alu_wen = 1'b1; alu_wa = 5'd7; alu_wmask = 4'h5;
        alu_wd = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) tick();
        n_tests++;
        if ({req_ready, busy, done, mem_req_valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/busy/done/mvld=%b want 1000", {req_ready, busy, done, mem_req_valid});
        end
        n_tests++;
        if ({vf_wen, vf_wa, vf_wmask, vf_wd} !== {1'b1, alu_wa, alu_wmask, alu_wd}) begin
            n_fail++;
            $display("FAIL reset_alu_pass: got wen=%b wa=%0d wm=%h want wen=1 wa=%0d wm=%h", vf_wen, vf_wa, vf_wmask, alu_wa, alu_wmask);
        end
        alu_wen = 1'b0;
        #1;
        n_tests++;
        if (vf_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wen_idle: got %b want 0", vf_wen);
        end
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_strided();
        logic [4:0]  rds[3]     = '{5'd8, 5'd13, 5'd22};
        logic [31:0] bases[3]   = '{32'h100, 32'h200, 32'h4};
        logic [31:0] strides[3] = '{32'h4, 32'h10, 32'hFFFFFFFC};
        logic [3:0]  masks[3]   = '{4'hF, 4'b1010, 4'hF};
        rdy_rand = 1'b0; max_dly = 1;
        for (int k = 0; k < 3; k++) begin
            int t0;
            bit ok;
            int j;
            logic [127:0] ew;
            issue_req(rds[k], bases[k], strides[k], masks[k], t0);
            wait_done(50, ok);
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL strided[%0d] timeout: no done within 50 cycles", k); end
            j = 0;
            for (int i = 0; i < 4; i++) begin
                if (masks[k][i]) begin
                    n_tests++;
                    if (j >= addr_log.size() || addr_log[j] !== bases[k] + 32'(i) * strides[k]) begin
                        n_fail++;
                        $display("FAIL strided[%0d] addr lane%0d: got %h want %h", k, i, addr_log[j], bases[k] + 32'(i) * strides[k]);
                    end
                    j++;
                end
            end
            n_tests++;
            if (addr_log.size() != j) begin n_fail++; $display("FAIL strided[%0d] nreads: got %0d want %0d", k, addr_log.size(), j); end
            ew = model_wd(bases[k], strides[k], masks[k]);
            n_tests++;
            if (wr_log.size() != 1 || {wr_log[0].wa, wr_log[0].wm, wr_log[0].wd} !== {rds[k][4:2], 2'b00, masks[k], ew}) begin
                n_fail++;
                $display("FAIL strided[%0d] write: got n=%0d wa=%0d wm=%h wd=%h want n=1 wa=%0d wm=%h wd=%h",
                         k, wr_log.size(), wr_log[0].wa, wr_log[0].wm, wr_log[0].wd, {rds[k][4:2], 2'b00}, masks[k], ew);
            end
            n_tests++;
            if (done_log.size() != 1 || done_log[0] != wr_log[0].c + 1) begin
                n_fail++;
                $display("FAIL strided[%0d] done: got n=%0d at %0d want 1 at %0d", k, done_log.size(), done_log[0], wr_log[0].c + 1);
            end
            if (k == 0) begin
                for (int i = 0; i < 4; i++) begin
                    n_tests++;
                    if (acyc_log[i] != t0 + 1 + i) begin
                        n_fail++;
                        $display("FAIL latency issue%0d: got cycle %0d want %0d", i, acyc_log[i] - t0, 1 + i);
                    end
                end
                n_tests++;
                if (wr_log[0].c != t0 + 6 || done_log[0] != t0 + 7 ||
                    wr_log[0].wd !== 128'hA5A5A4A9_A5A5A4AD_A5A5A4A1_A5A5A4A5) begin
                    n_fail++;
                    $display("FAIL latency wb: got wb@%0d done@%0d wd=%h want wb@6 done@7 wd=a5a5a4a9a5a5a4ada5a5a4a1a5a5a4a5",
                             wr_log[0].c - t0, done_log[0] - t0, wr_log[0].wd);
                end
            end
        end
    endtask

    task automatic test_alu_priority();
        int t0;
        bit ok;
        rdy_rand = 1'b0; max_dly = 1;
        issue_req(5'd12, 32'h300, 32'h8, 4'hF, t0);
        while (cyc < t0 + 6) tick();
        for (int i = 0; i < 3; i++) begin
            alu_wen = 1'b1; alu_wa = 5'($urandom); alu_wmask = 4'($urandom);
            alu_wd = {$urandom, $urandom, $urandom, $urandom};
            #2;
            n_tests++;
            if ({vf_wen, vf_wa, vf_wmask, vf_wd, busy} !== {1'b1, alu_wa, alu_wmask, alu_wd, 1'b1}) begin
                n_fail++;
                $display("FAIL alu_prio[%0d]: got wen=%b wa=%0d wm=%h busy=%b want wen=1 wa=%0d wm=%h busy=1",
                         i, vf_wen, vf_wa, vf_wmask, busy, alu_wa, alu_wmask);
            end
            tick();
        end
        alu_wen = 1'b0;
        wait_done(50, ok);
        n_tests++;
        if (!ok || wr_log.size() != 1 || wr_log[0].c != t0 + 9 || done_log[0] != t0 + 10 ||
            wr_log[0].wd !== model_wd(32'h300, 32'h8, 4'hF) || wr_log[0].wa !== 5'd12) begin
            n_fail++;
            $display("FAIL alu_prio load: got n=%0d wb@%0d done@%0d wa=%0d want n=1 wb@9 done@10 wa=12",
                     wr_log.size(), wr_log[0].c - t0, done_log[0] - t0, wr_log[0].wa);
        end
    endtask

    task automatic test_backpressure();
        rdy_rand = 1'b1; max_dly = 3;
        for (int r = 0; r < 3; r++) begin
            int t0;
            bit ok;
            issue_req(5'd8, 32'h100, 32'h4, 4'hF, t0);
            wait_done(200, ok);
            n_tests++;
            if (!ok || addr_log.size() != 4 || addr_log[0] !== 32'h100 || addr_log[3] !== 32'h10C) begin
                n_fail++;
                $display("FAIL bp[%0d] reads: got ok=%b n=%0d first=%h last=%h want ok=1 n=4 100..10c", r, ok, addr_log.size(), addr_log[0], addr_log[3]);
            end
            n_tests++;
            if (wr_log.size() != 1 || wr_log[0].wd !== model_wd(32'h100, 32'h4, 4'hF) ||
                done_log.size() != 1 || done_log[0] != wr_log[0].c + 1) begin
                n_fail++;
                $display("FAIL bp[%0d] write: got n=%0d wd=%h ndone=%0d want n=1 wd=%h ndone=1",
                         r, wr_log.size(), wr_log[0].wd, done_log.size(), model_wd(32'h100, 32'h4, 4'hF));
            end
        end
        rdy_rand = 1'b0; max_dly = 1;
    endtask

    task automatic test_zero_mask();
        int t0;
        issue_req(5'd4, 32'h40, 32'h4, 4'h0, t0);
        repeat (3) tick();
        n_tests++;
        if (done_log.size() != 1 || done_log[0] != t0 + 1 || addr_log.size() != 0 || wr_log.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_mask: got ndone=%0d done@%0d reads=%0d writes=%0d busy=%b want 1 @1 0 0 0",
                     done_log.size(), done_log[0] - t0, addr_log.size(), wr_log.size(), busy);
        end
    endtask

    task automatic test_reset_abort();
        int t0;
        bit ok;
        rdy_rand = 1'b0; max_dly = 3;
        issue_req(5'd16, 32'h500, 32'h4, 4'hF, t0);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: got busy=%b mvld=%b want 0 0", busy, mem_req_valid);
        end
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
        n_tests++;
        if (wr_log.size() != 0 || done_log.size() != 0 || busy !== 1'b0 || addr_log.size() != 2) begin
            n_fail++;
            $display("FAIL abort_quiet: got writes=%0d dones=%0d busy=%b reads=%0d want 0 0 0 2",
                     wr_log.size(), done_log.size(), busy, addr_log.size());
        end
        max_dly = 1;
        issue_req(5'd20, 32'h600, 32'hC, 4'b0111, t0);
        wait_done(50, ok);
        n_tests++;
        if (!ok || wr_log.size() != 1 || wr_log[0].wd !== model_wd(32'h600, 32'hC, 4'b0111) ||
            wr_log[0].wm !== 4'b0111 || wr_log[0].wa !== 5'd20 || done_log.size() != 1) begin
            n_fail++;
            $display("FAIL abort_next: got ok=%b n=%0d wd=%h wm=%h want ok=1 n=1 wd=%h wm=7",
                     ok, wr_log.size(), wr_log[0].wd, wr_log[0].wm, model_wd(32'h600, 32'hC, 4'b0111));
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            int t0;
            bit ok;
            int j;
            logic [4:0]  rd     = 5'($urandom);
            logic [31:0] base   = $urandom;
            logic [31:0] stride = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64));
            logic [3:0]  mask   = 4'($urandom_range(0, 15));
            rdy_rand = 1'($urandom_range(0, 1));
            max_dly  = int'($urandom_range(1, 3));
            issue_req(rd, base, stride, mask, t0);
            wait_done(200, ok);
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL rand[%0d] timeout: no done within 200 cycles", it); end
            j = 0;
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    n_tests++;
                    if (j >= addr_log.size() || addr_log[j] !== base + 32'(i) * stride) begin
                        n_fail++;
                        $display("FAIL rand[%0d] addr lane%0d: got %h want %h", it, i, addr_log[j], base + 32'(i) * stride);
                    end
                    j++;
                end
            end
            n_tests++;
            if (mask == 4'h0) begin
                if (wr_log.size() != 0 || addr_log.size() != 0 || done_log.size() != 1 || done_log[0] != t0 + 1) begin
                    n_fail++;
                    $display("FAIL rand[%0d] zero: got writes=%0d reads=%0d dones=%0d want 0 0 1", it, wr_log.size(), addr_log.size(), done_log.size());
                end
            end else if (addr_log.size() != j || wr_log.size() != 1 ||
                         {wr_log[0].wa, wr_log[0].wm, wr_log[0].wd} !== {rd[4:2], 2'b00, mask, model_wd(base, stride, mask)} ||
                         done_log.size() != 1 || done_log[0] != wr_log[0].c + 1) begin
                n_fail++;
                $display("FAIL rand[%0d] load: got reads=%0d writes=%0d wa=%0d wm=%h wd=%h want reads=%0d writes=1 wa=%0d wm=%h wd=%h",
                         it, addr_log.size(), wr_log.size(), wr_log[0].wa, wr_log[0].wm, wr_log[0].wd,
                         j, {rd[4:2], 2'b00}, mask, model_wd(base, stride, mask));
            end
        end
        rdy_rand = 1'b0; max_dly = 1;
    endtask

    initial begin
        test_reset();
        test_strided();
        test_alu_priority();
        test_backpressure();
        test_zero_mask();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
